// File: rtl/alu_scheduler.sv
// Shares one 32-bit ALU between two requesters; 64-bit ADD/SUB run as LO/HI(/FIX) passes.
// Latency 2/3/4 cycles from accept (narrow/wide/wide+fix); one op in flight, rsp held until rsp_ready.
module alu_scheduler #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [3:0]  req_op0,
  input  logic [3:0]  req_op1,
  input  logic [63:0] req_a0,
  input  logic [63:0] req_b0,
  input  logic [63:0] req_a1,
  input  logic [63:0] req_b1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [63:0] rsp_y,
  output logic        rsp_cout,
  output logic        rsp_zero,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_f,
  input  logic [31:0] alu_y,
  input  logic        alu_cout
);

  typedef enum logic [2:0] {IDLE, LO, HI, FIX, DONE} state_t;

  state_t      state;
  logic [2:0]  f;
  logic        wide;
  logic [63:0] a, b;
  logic        id;
  logic [31:0] y_lo, t;
  logic        c_lo, c_hi;
  logic        last;

  logic        grant;
  logic [3:0]  g_op;
  logic [63:0] g_a, g_b;
  logic        fix_needed;
  logic        go_done;
  logic [63:0] fin_y;
  logic        fin_cout;

  // With both valid, round-robin favours whoever was not granted last.
  always_comb begin
    if (FIXED_PRIO)
      grant = ~req_valid[0];
    else if (&req_valid)
      grant = ~last;
    else
      grant = req_valid[1];
  end

  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE && reset_n && req_valid[grant])
      req_ready = grant ? 2'b10 : 2'b01;
  end

  assign g_op = grant ? req_op1 : req_op0;
  assign g_a  = grant ? req_a1  : req_a0;
  assign g_b  = grant ? req_b1  : req_b0;

  always_comb begin
    alu_a = 32'd0;
    alu_b = 32'd0;
    alu_f = 3'b000;
    case (state)
      LO: begin
        alu_a = a[31:0];
        alu_b = b[31:0];
        alu_f = f;
      end
      HI: begin
        alu_a = a[63:32];
        alu_b = b[63:32];
        alu_f = f;
      end
      FIX: begin
        alu_a = t;
        alu_b = 32'd1;
        alu_f = f;
      end
      default: ;
    endcase
  end

  // A low-half carry (ADD) or borrow (SUB) is folded into the high half by a +/-1 pass.
  assign fix_needed = (f == 3'b010 && c_lo) || (f == 3'b110 && !c_lo);

  always_comb begin
    fin_y    = {alu_y, y_lo};
    fin_cout = alu_cout;
    go_done  = 1'b0;
    case (state)
      LO: begin
        fin_y   = {32'd0, alu_y};
        go_done = !wide;
      end
      HI:  go_done = !fix_needed;
      FIX: begin
        fin_cout = f[2] ? (c_hi & alu_cout) : (c_hi | alu_cout);
        go_done  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      f         <= 3'b000;
      wide      <= 1'b0;
      a         <= 64'd0;
      b         <= 64'd0;
      id        <= 1'b0;
      y_lo      <= 32'd0;
      t         <= 32'd0;
      c_lo      <= 1'b0;
      c_hi      <= 1'b0;
      last      <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_y     <= 64'd0;
      rsp_cout  <= 1'b0;
      rsp_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|(req_valid & req_ready)) begin
            f     <= g_op[2:0];
            wide  <= g_op[3] && (g_op[2:0] == 3'b010 || g_op[2:0] == 3'b110);
            a     <= g_a;
            b     <= g_b;
            id    <= grant;
            last  <= grant;
            state <= LO;
          end
        end
        LO: begin
          y_lo <= alu_y;
          c_lo <= alu_cout;
          if (!go_done)
            state <= HI;
        end
        HI: begin
          t    <= alu_y;
          c_hi <= alu_cout;
          if (!go_done)
            state <= FIX;
        end
        FIX: ;
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (go_done) begin
        rsp_y     <= fin_y;
        rsp_cout  <= fin_cout;
        rsp_zero  <= (fin_y == 64'd0);
        rsp_id    <= id;
        rsp_valid <= 1'b1;
        state     <= DONE;
      end
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler: behavioural ALU, scoreboard of expected responses, directed timing checks.
module tb_alu_scheduler;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [1:0]  req_valid, req_ready;
  logic [3:0]  req_op0, req_op1;
  logic [63:0] req_a0, req_b0, req_a1, req_b1;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_zero;
  logic [63:0] rsp_y;
  logic [31:0] alu_a, alu_b, alu_y;
  logic [2:0]  alu_f;
  logic        alu_cout;

  logic [1:0]  fp_req_valid, fp_req_ready;
  logic        fp_rsp_valid, fp_rsp_ready, fp_rsp_id, fp_rsp_cout, fp_rsp_zero;
  logic [63:0] fp_rsp_y;
  logic [31:0] fp_alu_a, fp_alu_b, fp_alu_y;
  logic [2:0]  fp_alu_f;
  logic        fp_alu_cout;

  typedef struct packed {
    logic        id;
    logic [63:0] y;
    logic        cout;
    logic        zero;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc = 0;

  function automatic logic [32:0] alu_m(input logic [31:0] x, input logic [31:0] y, input logic [2:0] fn);
    logic [31:0] bb;
    logic [32:0] s;
    logic [31:0] r;
    bb = fn[2] ? ~y : y;
    s  = {1'b0, x} + {1'b0, bb} + {32'd0, fn[2]};
    case (fn[1:0])
      2'b00:   r = x & bb;
      2'b01:   r = x | bb;
      2'b10:   r = s[31:0];
      default: r = {31'd0, s[31]};
    endcase
    return {s[32], r};
  endfunction

  function automatic exp_t model(input logic rid, input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
    exp_t        e;
    logic [64:0] s;
    logic [32:0] r;
    e.id = rid;
    if (op == 4'b1010) begin
      s      = {1'b0, x} + {1'b0, y};
      e.y    = s[63:0];
      e.cout = s[64];
    end else if (op == 4'b1110) begin
      s      = {1'b0, x} + {1'b0, ~y} + 65'd1;
      e.y    = s[63:0];
      e.cout = s[64];
    end else begin
      r      = alu_m(x[31:0], y[31:0], op[2:0]);
      e.y    = {32'd0, r[31:0]};
      e.cout = r[32];
    end
    e.zero = (e.y == 64'd0);
    return e;
  endfunction

  assign {alu_cout, alu_y}       = alu_m(alu_a, alu_b, alu_f);
  assign {fp_alu_cout, fp_alu_y} = alu_m(fp_alu_a, fp_alu_b, fp_alu_f);

  alu_scheduler #(.FIXED_PRIO(1'b0)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_y(rsp_y), .rsp_cout(rsp_cout), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .alu_y(alu_y), .alu_cout(alu_cout)
  );

  alu_scheduler #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .reset_n(reset_n),
    .req_valid(fp_req_valid), .req_ready(fp_req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .rsp_valid(fp_rsp_valid), .rsp_ready(fp_rsp_ready), .rsp_id(fp_rsp_id),
    .rsp_y(fp_rsp_y), .rsp_cout(fp_rsp_cout), .rsp_zero(fp_rsp_zero),
    .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_f(fp_alu_f),
    .alu_y(fp_alu_y), .alu_cout(fp_alu_cout)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Push on accept, pop and compare on response handshake.
  always @(negedge clk) begin
    if (reset_n) begin
      if (req_valid != 2'b00)
        check("ready_onehot", 64'($onehot0(req_ready)), 64'd1);
      if (req_valid[0] && req_ready[0]) sb.push_back(model(1'b0, req_op0, req_a0, req_b0));
      if (req_valid[1] && req_ready[1]) sb.push_back(model(1'b1, req_op1, req_a1, req_b1));
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_rsp", 64'(sb.size()), 64'd1);
        end else begin
          e_mon = sb.pop_front();
          check("sb_id",   64'(rsp_id),   64'(e_mon.id));
          check("sb_y",    rsp_y,         e_mon.y);
          check("sb_cout", 64'(rsp_cout), 64'(e_mon.cout));
          check("sb_zero", 64'(rsp_zero), 64'(e_mon.zero));
        end
      end
    end
  end

  task automatic send(input int r, input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    if (r == 0) begin
      req_op0 = op; req_a0 = x; req_b0 = y; req_valid[0] = 1'b1;
    end else begin
      req_op1 = op; req_a1 = x; req_b1 = y; req_valid[1] = 1'b1;
    end
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready[r]) begin
        got = 1'b1;
        acc = cyc;
        break;
      end
    end
    check("accept", 64'(got), 64'd1);
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int lat);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_seen"}, 64'(seen), 64'd1);
    if (seen) check({tag, "_lat"}, 64'(cyc - acc), 64'(lat));
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !rsp_valid) break;
    end
    check({tag, "_drain"}, 64'(sb.size()), 64'd0);
  endtask

  int ids[$];
  int fp_ids[$];
  logic [63:0] fp_y[$];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1;
    req_op0 = 4'd0; req_op1 = 4'd0;
    req_a0 = 64'd0; req_b0 = 64'd0; req_a1 = 64'd0; req_b1 = 64'd0;
    fp_req_valid = 2'b00; fp_rsp_ready = 1'b1;

    #12 req_valid = 2'b11;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_zero",  64'(rsp_zero),  64'd0);
    check("rst_alu_f",     64'(alu_f),     64'd0);
    req_valid = 2'b00;
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    check("idle_alu_a", 64'(alu_a), 64'd0);
    check("idle_alu_f", 64'(alu_f), 64'd0);

    send(0, 4'b0010, 64'd3, 64'd5);
    wait_rsp("add32", 2);
    check("add32_y", rsp_y, 64'd8);
    check("add32_cout", 64'(rsp_cout), 64'd0);
    check("add32_id", 64'(rsp_id), 64'd0);

    send(0, 4'b0111, 64'd31, 64'd40);
    wait_rsp("slt", 2);
    check("slt_y", rsp_y, 64'd1);

    send(0, 4'b0110, 64'd12, 64'd24);
    wait_rsp("sub32", 2);
    check("sub32_y", rsp_y, 64'h0000_0000_FFFF_FFF4);
    check("sub32_cout", 64'(rsp_cout), 64'd0);

    send(1, 4'b1001, 64'h1234_5678_0000_00F0, 64'hFFFF_0000_0000_000F);
    wait_rsp("wide_or", 2);
    check("wide_or_y", rsp_y, 64'h0000_0000_0000_00FF);

    send(0, 4'b1010, 64'h0000_0000_FFFF_FFFF, 64'd1);
    wait_rsp("addfix", 4);
    check("addfix_y", rsp_y, 64'h0000_0001_0000_0000);
    check("addfix_cout", 64'(rsp_cout), 64'd0);

    send(1, 4'b1010, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    wait_rsp("addnofix", 3);
    check("addnofix_y", rsp_y, 64'd0);
    check("addnofix_cout", 64'(rsp_cout), 64'd1);
    check("addnofix_zero", 64'(rsp_zero), 64'd1);

    send(0, 4'b1110, 64'h0000_0001_0000_0000, 64'd1);
    wait_rsp("subfix", 4);
    check("subfix_y", rsp_y, 64'h0000_0000_FFFF_FFFF);
    check("subfix_cout", 64'(rsp_cout), 64'd1);

    send(0, 4'b1110, 64'd0, 64'd1);
    wait_rsp("subneg", 4);
    check("subneg_y", rsp_y, 64'hFFFF_FFFF_FFFF_FFFF);
    check("subneg_cout", 64'(rsp_cout), 64'd0);

    // Backpressure: response must hold while requester 1 waits.
    @(posedge clk); #1 rsp_ready = 1'b0;
    send(0, 4'b0010, 64'd100, 64'd23);
    wait_rsp("bp", 2);
    @(posedge clk); #1;
    req_op1 = 4'b0010; req_a1 = 64'd7; req_b1 = 64'd8; req_valid[1] = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("bp_valid", 64'(rsp_valid), 64'd1);
      check("bp_y", rsp_y, 64'd123);
      check("bp_req_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_exit_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    check("bp_resume_ready", 64'(req_ready), 64'd2);
    @(posedge clk); #1 req_valid = 2'b00;
    drain("bp");

    // Round-robin with both requesters held valid.
    @(posedge clk); #1;
    req_op0 = 4'b0010; req_a0 = 64'd1; req_b0 = 64'd1;
    req_op1 = 4'b0010; req_a1 = 64'd2; req_b1 = 64'd2;
    req_valid = 2'b11;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) ids.push_back(int'(rsp_id));
      if (ids.size() == 4) break;
    end
    @(posedge clk); #1 req_valid = 2'b00;
    check("rr_count", 64'(ids.size()), 64'd4);
    foreach (ids[i]) check($sformatf("rr_id%0d", i), 64'(ids[i]), 64'(i % 2));
    drain("rr");

    // Fixed priority: requester 0 always wins.
    @(posedge clk); #1 fp_req_valid = 2'b11;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (fp_rsp_valid && fp_rsp_ready) begin
        fp_ids.push_back(int'(fp_rsp_id));
        fp_y.push_back(fp_rsp_y);
      end
      if (fp_ids.size() == 4) break;
    end
    @(posedge clk); #1 fp_req_valid = 2'b00;
    check("fp_count", 64'(fp_ids.size()), 64'd4);
    foreach (fp_ids[i]) begin
      check($sformatf("fp_id%0d", i), 64'(fp_ids[i]), 64'd0);
      check($sformatf("fp_y%0d", i), fp_y[i], 64'd2);
    end

    // Reset during the HI pass discards the op.
    send(0, 4'b1010, 64'h0000_0005_FFFF_FFFF, 64'd1);
    @(posedge clk); #1;
    check("hi_alu_a", 64'(alu_a), 64'd5);
    req_op1 = 4'b0010; req_a1 = 64'd4; req_b1 = 64'd4; req_valid = 2'b10;
    reset_n = 1'b0;
    #1;
    check("mrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mrst_req_ready", 64'(req_ready), 64'd0);
    check("mrst_alu_a",     64'(alu_a),     64'd0);
    check("mrst_alu_b",     64'(alu_b),     64'd0);
    check("mrst_alu_f",     64'(alu_f),     64'd0);
    check("mrst_rsp_y",     rsp_y,          64'd0);
    check("mrst_rsp_cout",  64'(rsp_cout),  64'd0);
    check("mrst_rsp_zero",  64'(rsp_zero),  64'd0);
    check("mrst_rsp_id",    64'(rsp_id),    64'd0);
    sb.delete();
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("mrst_no_rsp", 64'(rsp_valid), 64'd0);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    reset_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("post_rst_quiet", 64'(rsp_valid), 64'd0);
    end
    send(1, 4'b0010, 64'd9, 64'd10);
    wait_rsp("post_rst", 2);
    check("post_rst_y", rsp_y, 64'd19);
    check("post_rst_id", 64'(rsp_id), 64'd1);
    drain("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Sequencer/arbiter that shares one combinational 32-bit ALU (f: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; cin = f[2]) between two requesters. It runs 32-bit ops in one ALU pass and 64-bit ADD/SUB as multi-pass sequences with carry/borrow fix-up, then returns the result on a tagged response channel. It sits between the requesting units and the ALU instance, and drives all ALU inputs.

## Interface
- FIXED_PRIO, 0: 0 = round-robin arbitration; 1 = requester 0 always wins.
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  request valid, bit i = requester i.
- req_ready  out  2  request accepted this cycle (one-hot or zero).
- req_op0, req_op1  in  4  {wide, f[2:0]}.
- req_a0, req_b0, req_a1, req_b1  in  64  operands; narrow ops use [31:0].
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  1  requester index of result.
- rsp_y  out  64  result.
- rsp_cout  out  1  carry (ADD) / no-borrow (SUB) of the full-width op.
- rsp_zero  out  1  rsp_y == 0.
- alu_a, alu_b  out  32  ALU operands.
- alu_f  out  3  ALU function.
- alu_y  in  32  ALU result.
- alu_cout  in  1  ALU carry out.

## Operation
- States: IDLE, LO, HI, FIX, DONE.
- IDLE: grant = arbitration over req_valid. Assert req_ready[grant]; on req_valid & req_ready, latch op, a, b, id, then go to LO. The requester holds valid and operands stable until accepted.
- Round-robin: when both are valid, grant the requester not granted last. The pointer updates only on accept; after reset it favours 0.
- `wide` is honoured only for f=010/110; for any other f it is ignored and the op is narrow.
- LO: alu_a=a[31:0], alu_b=b[31:0], alu_f=f. Latch y_lo=alu_y and c_lo=alu_cout.
  - Narrow: go to DONE. rsp_y={32'0, y_lo}, rsp_cout=c_lo.
- HI (wide): alu_a=a[63:32], alu_b=b[63:32], alu_f=f. Latch t=alu_y and c_hi=alu_cout.
  - Fix needed if (ADD and c_lo=1) or (SUB and c_lo=0). Fix needed → FIX, else → DONE with y_hi=t, cout=c_hi.
- FIX: alu_a=t, alu_b=32'd1, alu_f=f (ADD adds 1; SUB subtracts 1). y_hi=alu_y.
  - ADD: cout = c_hi | alu_cout.
  - SUB: cout = c_hi & alu_cout.
  - Then → DONE.
- DONE: rsp_valid=1; rsp_y, rsp_id, rsp_cout, rsp_zero are held stable. On rsp_ready → IDLE.
  - No request is accepted in the DONE→IDLE transition cycle.
- ALU outputs are 0 with alu_f=000 in IDLE and DONE.
- Reset (asynchronous, any state): state=IDLE, any in-flight op discarded with no response, RR pointer=0. All outputs 0, including req_ready, which is forced 0 while reset_n is low.

## Timing
- Accept at edge T. Response visible after edge T+2 (narrow), T+3 (wide, no fix) or T+4 (wide with fix).
- The ALU path is combinational within each state cycle; alu_y/alu_cout are sampled at the end of that cycle.
- Throughput: at most one op in flight. Minimum 3 cycles per narrow op with rsp_ready tied high (accept, LO, DONE).
- req_ready is combinational from state and req_valid, with no dependency on rsp_ready.
- rsp_valid stays asserted under backpressure indefinitely; the response is never dropped or overwritten.

## Test plan
- Narrow ops on req0: f=010, a=3, b=5 → rsp_y=8, cout=0, id=0, rsp_valid 2 cycles after accept. f=111, a=31, b=40 → rsp_y=1. f=110, a=12, b=24 → rsp_y[31:0]=0xFFFFFFF4, cout=0.
- Wide ADD with FIX: a=0x00000000_FFFFFFFF, b=1 → rsp_y=0x00000001_00000000, cout=0, FIX visited, response 4 cycles after accept. a=b=0x80000000_00000000 → rsp_y=0, cout=1, zero=1.
- Wide SUB: a=0x00000001_00000000, b=1 → rsp_y=0x00000000_FFFFFFFF, cout=1. a=0, b=1 → rsp_y=all ones, cout=0.
- Arbitration: both req_valid held high with narrow ops, rsp_ready=1 → rsp_id sequence 0,1,0,1. With FIXED_PRIO=1 → 0,0,0,0.
- Backpressure: rsp_ready low for 5 cycles in DONE → rsp_valid and data stable, req_ready=00 throughout. Accept resumes the cycle after DONE exits.
- Reset mid-op: reset_n low during HI → all outputs 0 immediately and no response. After release, a new narrow op completes normally.
